vedic_mac_accumulator: RTL
==========================

// Module: vedic_mac_accumulator
// PURPOSE
//  Downstream consumer of the 8x8 Vedic multiplier: accepts a stream of 16-bit
//  products plus the overflow flag under valid/ready handshake, and sums a
//  programmed number of them into an ACC_W-bit accumulator.
//  Presents the registered sum with a sticky overflow flag under a second
//  valid/ready handshake. Forms the MAC tail of the multiplier datapath.
// PARAMETERS
//  ACC_W  24  accumulator/result width; must be >= 16
//  LEN_W  8   width of the product-count field len
// PORTS
//  clk        in   1      single clock, rising edge
//  rst_n      in   1      asynchronous, active-low reset
//  start      in   1      begin a run; sampled only in IDLE
//  len        in   LEN_W  number of products in the run; sampled with start
//  in_valid   in   1      prod/prod_ovf are valid
//  in_ready   out  1      block accepts a product this cycle
//  prod       in   16     product from the multiplier
//  prod_ovf   in   1      overflow flag from the multiplier, same beat as prod
//  out_valid  out  1      acc_out/acc_ovf are valid
//  out_ready  in   1      consumer takes the result
//  acc_out    out  ACC_W  accumulated sum
//  acc_ovf    out  1      sticky: ACC_W carry-out or any prod_ovf seen in run
//  busy       out  1      high in ACCUM or DONE
// BEHAVIOUR
//  - One clock. Reset is asynchronous and active-low: rst_n=0 forces IDLE, and
//    clears acc, count, acc_out, acc_ovf, in_ready, out_valid and busy to 0.
//  - The FSM has three states, each with a fixed output pattern:
//    IDLE:  in_ready=0, out_valid=0, busy=0.
//    ACCUM: in_ready=1, busy=1.
//    DONE:  out_valid=1, busy=1.
//  - IDLE: start=1 and len!=0 loads cnt=len, acc=0 and ovf=0, then enters ACCUM
//    on the next cycle. start with len=0 is ignored and the FSM stays in IDLE.
//  - ACCUM: a beat is accepted when in_valid && in_ready. On each beat:
//    acc <= acc + {0,prod}, with the sum truncated to ACC_W bits (wrap).
//    ovf <= ovf | carry_out(ACC_W) | prod_ovf.
//    cnt <= cnt-1.
//    A beat with cnt==1 enters DONE.
//  - Latency: out_valid goes high on the cycle after the last accepted beat.
//    acc_out/acc_ovf are registered and stable for as long as out_valid=1.
//  - DONE: out_valid && out_ready gives one-cycle handover, then IDLE. The
//    result holds indefinitely while out_ready=0.
//  - start is ignored in ACCUM and DONE.
//  - in_ready is 0 in DONE and IDLE, so products are never dropped or
//    double-counted.
//  - Back-to-back runs: start is not accepted in the handover cycle itself, so
//    the earliest new start is one cycle after the handover.
//  - A product of 0 is a valid beat and still decrements cnt.
//  - When rst_n is deasserted mid-run, the block resumes from IDLE. The partial
//    sum is lost and no out_valid is produced for that run.
// CONFIGURATION
//  VEDIC_MAC_SAT_EN:
//    Defined: when a beat produces carry_out(ACC_W), acc is set to all-ones.
//    After that, further beats leave acc at all-ones (saturating). acc_ovf
//    behaves the same as without the macro.
//    Undefined: acc wraps modulo 2^ACC_W and acc_ovf still flags the event.
// TESTING
//  1 Basic: ACC_W=24, len=3, three beats of prod=16'hFE01 (255*255)
//    -> out_valid one cycle after the 3rd beat, acc_out=24'h02FA03, acc_ovf=0.
//  2 Input stall: len=2, in_valid gaps of 4 cycles, prod=16'h0010 then 16'h0020
//    -> acc_out=24'h000030. in_ready stays 1 in ACCUM.
//  3 Output backpressure: run len=1, prod=16'h1234, out_ready=0 for 5 cycles
//    -> out_valid and acc_out=24'h001234 held 5 cycles, IDLE one cycle after
//    out_ready=1. start in DONE ignored.
//  4 Overflow: ACC_W=17, len=3, prod=16'hFE01 x3
//    -> no SAT: acc_out=17'h0FA03, acc_ovf=1.
//    -> VEDIC_MAC_SAT_EN: acc_out=17'h1FFFF, acc_ovf=1.
//  5 prod_ovf: len=2, beat1 prod=16'h0001 with prod_ovf=1, beat2 prod=16'h0001
//    -> acc_out=2, acc_ovf=1.
//  6 Reset/len edge cases:
//    start with len=0 -> stays IDLE, busy=0.
//    rst_n low after 1 of 3 beats -> all outputs 0 asynchronously. A fresh
//    len=1, prod=16'h0005 run then gives acc_out=5.

Source files
------------

// File: rtl/vedic_mac_accumulator.sv
// vedic_mac_accumulator: MAC tail of the Vedic multiplier datapath.
// Optional saturation enabled by defining VEDIC_MAC_SAT_EN.
module vedic_mac_accumulator #(
    parameter int ACC_W = 24,
    parameter int LEN_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [LEN_W-1:0] len,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [15:0]      prod,
    input  logic             prod_ovf,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] acc_out,
    output logic             acc_ovf,
    output logic             busy
);

    typedef enum logic [1:0] {
        IDLE,
        ACCUM,
        DONE
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [LEN_W-1:0] cnt;
    logic [ACC_W-1:0] acc;
    logic             ovf;
    logic             beat;
    logic             load;
    logic [ACC_W:0]   sum;
    logic [ACC_W-1:0] acc_nxt;

    assign load = (state == IDLE) && start && (len != '0);
    assign beat = (state == ACCUM) && in_valid;
    assign sum  = {1'b0, acc} + {{(ACC_W - 15){1'b0}}, prod};

`ifdef VEDIC_MAC_SAT_EN
    // carry-out pins the sum at all-ones; later carries keep it there
    assign acc_nxt = sum[ACC_W] ? {ACC_W{1'b1}} : sum[ACC_W-1:0];
`else
    assign acc_nxt = sum[ACC_W-1:0];
`endif

    // state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // next state and per-state output pattern
    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b0;
        unique case (state)
            IDLE: begin
                if (load) state_nxt = ACCUM;
            end
            ACCUM: begin
                in_ready = 1'b1;
                busy     = 1'b1;
                if (beat && cnt == LEN_W'(1)) state_nxt = DONE;
            end
            DONE: begin
                out_valid = 1'b1;
                busy      = 1'b1;
                if (out_ready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // accumulator, sticky overflow and beat counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
            acc <= '0;
            ovf <= 1'b0;
        end else if (load) begin
            cnt <= len;
            acc <= '0;
            ovf <= 1'b0;
        end else if (beat) begin
            cnt <= cnt - 1'b1;
            acc <= acc_nxt;
            ovf <= ovf | sum[ACC_W] | prod_ovf;
        end
    end

    assign acc_out = acc;
    assign acc_ovf = ovf;

endmodule
